sprite_scan_store: RTL and testbench
====================================

Name: sprite_scan_store

Overview:
- Parametrised successor to the fixed 10-slot sprite store and match logic in the PPU sprite path.
- During the OAM scan, filters OAM entries against the current line (8- or 16-row mode) and stores up to MAX_SPRITES hits in slots, in OAM order.
- During render, flags the lowest-numbered unconsumed slot whose X equals the pixel X and holds it until the fetcher acknowledges it.
- Sits between the OAM reader and the sprite fetcher.

Parameters:
- MAX_SPRITES, 10, number of store slots (1..16).
- OAM_ENTRIES, 40, OAM entries examined per scan (1..64).
- IDX_W, 6, OAM index width; must satisfy 2**IDX_W >= OAM_ENTRIES.
- SLOT_W, 4, slot number width; must satisfy 2**SLOT_W >= MAX_SPRITES.

Ports:
- clk1  in  1  clock; all state updates on rising edge.
- reset_video  in  1  synchronous reset, active-high.
- scan_start  in  1  one-cycle pulse that clears the store and enters SCAN.
- line  in  8  current line number (LY), sampled every scan cycle.
- tall_mode  in  1  0 = 8-row sprites, 1 = 16-row sprites; sampled on scan_start.
- oam_valid  in  1  OAM entry present this cycle.
- oam_y  in  8  raw OAM Y byte.
- oam_x  in  8  raw OAM X byte.
- oam_idx  in  IDX_W  OAM entry number.
- render_en  in  1  pixel pipeline active.
- cur_x  in  8  current pixel X, compared in raw OAM X space.
- fetch_done  in  1  fetcher finished the presented sprite.
- scan_busy  out  1  high in SCAN.
- store_count  out  SLOT_W  number of slots filled.
- match_valid  out  1  match presented; also the fetcher stall request.
- match_slot  out  SLOT_W  slot number of the presented match.
- match_idx  out  IDX_W  OAM index of the presented match.
- match_row  out  4  row offset inside the sprite.
- overflow  out  1  sticky: a hit was dropped (see Optional Feature).

Behaviour:
- Reset:
  - state = IDLE.
  - All slot valid bits cleared; store_count = 0; entry counter = 0.
  - All outputs 0.
- States: IDLE, SCAN, READY, RENDER.
- Transitions:
  - IDLE -> SCAN on scan_start.
  - SCAN -> READY in the cycle after the OAM_ENTRIES-th accepted oam_valid.
  - READY -> RENDER when render_en = 1.
  - RENDER -> IDLE when render_en = 0.
  - scan_start in any state, including mid-SCAN or RENDER: the store is cleared and the block enters SCAN next cycle. scan_start takes precedence over all other inputs.
- Scan filtering, per oam_valid cycle in SCAN:
  - diff = (line + 16 - oam_y) mod 256.
  - hit = diff < (tall_mode ? 16 : 8).
  - On hit with store_count < MAX_SPRITES: write {oam_idx, oam_x, diff[3:0]} to slot[store_count], set its valid bit, and increment store_count. All of this takes effect the next cycle.
  - On hit with store_count = MAX_SPRITES: the entry is dropped.
  - oam_valid outside SCAN is ignored.
  - The entry counter advances only on oam_valid, so gaps in oam_valid are allowed.
- Render matching, combinational from registered slot state:
  - candidate = valid && !consumed && slot.x == cur_x.
  - The lowest slot number among candidates wins.
  - match_valid/slot/idx/row are registered, one cycle after cur_x changes.
  - The match is held stable while match_valid = 1 and fetch_done = 0, even if cur_x changes.
- fetch_done while match_valid = 1:
  - Sets consumed on the presented slot and drops match_valid next cycle.
  - The next candidate at the same X, if any, is presented the following cycle. Minimum gap between matches is 1 cycle.
  - fetch_done with match_valid = 0 is ignored.
- Matching is active only in RENDER; outputs are 0 elsewhere.
- cur_x = 0: slots with x = 0 match normally (the caller decides visibility).
- 16-row mode: match_row spans 0..15. In 8-row mode match_row[3] = 0.

Optional Feature:
- Macro: SPRITE_STORE_OVERFLOW_EN.
- Defined:
  - overflow sets on the first dropped hit and stays set until scan_start or reset.
  - An internal 6-bit dropped-hit counter, saturating at 63, is readable by hierarchical reference for debug.
- Undefined:
  - overflow is tied to 0 and the counter is not built.
  - Store behaviour is identical in both cases.

Test Plan:
- Basic scan: line = 20, tall_mode = 0, 40 entries with oam_y = 36 only at idx 3 and 17 -> store_count = 2, READY after the 40th entry.
- Tall mode: line = 20, tall_mode = 1, oam_y = 25 -> diff = 11, hit stored with match_row = 11. With tall_mode = 0 the same entry is not stored.
- Overflow: 12 consecutive hitting entries, MAX_SPRITES = 10 -> store_count = 10; entries 10 and 11 dropped; overflow = 1 only with SPRITE_STORE_OVERFLOW_EN defined.
- Priority and hold: slots 2 and 5 both x = 40, cur_x = 40 -> slot 2 presented and held across cur_x changes until fetch_done; then slot 5 presented the following cycle; after its fetch_done, match_valid = 0.
- Restart: scan_start mid-SCAN at entry 20 with 3 stored -> store_count = 0 next cycle, scan restarts counting from 0; reset_video asserted mid-RENDER -> IDLE and all outputs 0 on the next edge.
- Wrap: line = 250, oam_y = 10 -> diff = 0, hit; oam_y = 0 with line = 0 -> diff = 16, no hit in either mode.

Source files
------------

// File: rtl/sprite_scan_store.sv
// Sprite scan store: filters OAM entries against the current line during SCAN, keeps up to MAX_SPRITES hits in OAM order.
// Latency: a stored hit is visible one cycle after its oam_valid; a render match is registered one cycle after cur_x.
// Backpressure: match_valid doubles as the fetcher stall; a match is held until fetch_done, and the next one follows after a 1-cycle gap.
//
// Ports:
//   clk1, reset_video         clock and synchronous active-high reset
//   scan_start, line,         scan control: scan_start clears the store and enters SCAN;
//   tall_mode                 tall_mode is sampled on scan_start, line every scan cycle
//   oam_valid/y/x/idx         OAM entry stream, consumed only in SCAN
//   render_en, cur_x,         render control, pixel X in raw OAM X space, and the
//   fetch_done                fetcher acknowledge
//   scan_busy, store_count    scan status and number of filled slots
//   match_valid/slot/idx/row  presented match (all zero outside RENDER)
//   overflow                  sticky dropped-hit flag
//
// Optional build macro SPRITE_STORE_OVERFLOW_EN: when defined, overflow is live and a
// saturating 6-bit dropped-hit counter (drop_cnt) is kept for debug; when undefined,
// overflow is tied low. Store behaviour is identical either way.
//
// Parameter limits: MAX_SPRITES 1..16, OAM_ENTRIES 1..64, 2**IDX_W >= OAM_ENTRIES,
// 2**SLOT_W >= MAX_SPRITES.

module sprite_scan_store #(
  parameter int MAX_SPRITES = 10,
  parameter int OAM_ENTRIES = 40,
  parameter int IDX_W       = 6,
  parameter int SLOT_W      = 4
) (
  input  logic              clk1,
  input  logic              reset_video,
  input  logic              scan_start,
  input  logic [7:0]        line,
  input  logic              tall_mode,
  input  logic              oam_valid,
  input  logic [7:0]        oam_y,
  input  logic [7:0]        oam_x,
  input  logic [IDX_W-1:0]  oam_idx,
  input  logic              render_en,
  input  logic [7:0]        cur_x,
  input  logic              fetch_done,
  output logic              scan_busy,
  output logic [SLOT_W-1:0] store_count,
  output logic              match_valid,
  output logic [SLOT_W-1:0] match_slot,
  output logic [IDX_W-1:0]  match_idx,
  output logic [3:0]        match_row,
  output logic              overflow
);

  // One extra bit on both counters so they can hold the full value
  // (MAX_SPRITES may equal 2**SLOT_W, OAM_ENTRIES may equal 2**IDX_W).
  localparam int CNT_W = SLOT_W + 1;
  localparam int ENT_W = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_READY  = 2'd2,
    ST_RENDER = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0] fill_cnt;
  logic [ENT_W-1:0] ent_cnt;
  logic             tall_q;

  logic [MAX_SPRITES-1:0] slot_vld;
  logic [MAX_SPRITES-1:0] slot_used;
  logic [IDX_W-1:0]       slot_idx [MAX_SPRITES];
  logic [7:0]             slot_x   [MAX_SPRITES];
  logic [3:0]             slot_row [MAX_SPRITES];

  // ---------------------------------------------------------------------------
  // Scan filter
  // ---------------------------------------------------------------------------
  logic [7:0] diff;
  logic       hit;
  logic       scan_acc;
  logic       store_wr;
  logic       scan_last;

  // scan_start wins over a same-cycle OAM entry: the entry is discarded.
  assign scan_acc  = (state == ST_SCAN) && oam_valid && !scan_start;
  // OAM Y is stored with a +16 bias; mod-256 arithmetic lets sprites wrap
  // around the top of the line space.
  assign diff      = line + 8'd16 - oam_y;
  assign hit       = tall_q ? (diff < 8'd16) : (diff < 8'd8);
  assign store_wr  = scan_acc && hit && (fill_cnt < CNT_W'(MAX_SPRITES));
  assign scan_last = scan_acc && (ent_cnt == ENT_W'(OAM_ENTRIES - 1));

  // ---------------------------------------------------------------------------
  // Render candidate selection (combinational, from registered slot state)
  // ---------------------------------------------------------------------------
  logic [MAX_SPRITES-1:0] cand;
  logic                   any_cand;
  logic [SLOT_W-1:0]      win_slot;
  logic [IDX_W-1:0]       win_idx;
  logic [3:0]             win_row;

  always_comb begin
    cand = '0;
    for (int i = 0; i < MAX_SPRITES; i++) begin
      cand[i] = slot_vld[i] && !slot_used[i] && (slot_x[i] == cur_x);
    end
  end

  // Walk from the top slot down so the lowest-numbered candidate is the
  // last assignment and therefore wins.
  always_comb begin
    any_cand = 1'b0;
    win_slot = '0;
    win_idx  = '0;
    win_row  = '0;
    for (int i = MAX_SPRITES - 1; i >= 0; i--) begin
      if (cand[i]) begin
        any_cand = 1'b1;
        win_slot = SLOT_W'(i);
        win_idx  = slot_idx[i];
        win_row  = slot_row[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk1) begin
    if (reset_video) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (scan_start) begin
      state_nxt = ST_SCAN;
    end else begin
      case (state)
        ST_IDLE:   state_nxt = ST_IDLE;
        ST_SCAN:   if (scan_last)  state_nxt = ST_READY;
        ST_READY:  if (render_en)  state_nxt = ST_RENDER;
        ST_RENDER: if (!render_en) state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs
  logic              mv_q;
  logic [SLOT_W-1:0] ms_q;
  logic [IDX_W-1:0]  mi_q;
  logic [3:0]        mr_q;

  always_comb begin
    scan_busy   = (state == ST_SCAN);
    // Full count of a 2**SLOT_W store does not fit SLOT_W bits and reads as 0.
    store_count = fill_cnt[SLOT_W-1:0];
    match_valid = mv_q;
    match_slot  = ms_q;
    match_idx   = mi_q;
    match_row   = mr_q;
  end

  // ---------------------------------------------------------------------------
  // Slot store, entry counter, consumed bits
  // ---------------------------------------------------------------------------
  logic render_act;
  logic fetch_ack;

  // Matching runs only while RENDER persists; leaving it (render_en low,
  // scan_start) zeroes the match registers on the same edge.
  assign render_act = (state == ST_RENDER) && (state_nxt == ST_RENDER);
  assign fetch_ack  = mv_q && fetch_done;

  always_ff @(posedge clk1) begin
    if (reset_video) begin
      fill_cnt  <= '0;
      ent_cnt   <= '0;
      tall_q    <= 1'b0;
      slot_vld  <= '0;
      slot_used <= '0;
      for (int i = 0; i < MAX_SPRITES; i++) begin
        slot_idx[i] <= '0;
        slot_x[i]   <= '0;
        slot_row[i] <= '0;
      end
    end else if (scan_start) begin
      fill_cnt  <= '0;
      ent_cnt   <= '0;
      tall_q    <= tall_mode;
      slot_vld  <= '0;
      slot_used <= '0;
    end else begin
      if (scan_acc) begin
        ent_cnt <= ent_cnt + ENT_W'(1);
      end
      if (store_wr) begin
        fill_cnt <= fill_cnt + CNT_W'(1);
      end
      for (int i = 0; i < MAX_SPRITES; i++) begin
        if (store_wr && (fill_cnt == CNT_W'(i))) begin
          slot_vld[i] <= 1'b1;
          slot_idx[i] <= oam_idx;
          slot_x[i]   <= oam_x;
          slot_row[i] <= diff[3:0];
        end
        if (fetch_ack && (ms_q == SLOT_W'(i))) begin
          slot_used[i] <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Match presentation registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk1) begin
    if (reset_video || !render_act) begin
      mv_q <= 1'b0;
      ms_q <= '0;
      mi_q <= '0;
      mr_q <= '0;
    end else if (mv_q && !fetch_done) begin
      // Hold the presented sprite while the fetcher is busy, even if cur_x moves.
      mv_q <= 1'b1;
    end else if (mv_q) begin
      // Acknowledged: one idle cycle lets the consumed bit settle before the
      // next candidate at this X is selected.
      mv_q <= 1'b0;
      ms_q <= '0;
      mi_q <= '0;
      mr_q <= '0;
    end else begin
      mv_q <= any_cand;
      ms_q <= win_slot;
      mi_q <= win_idx;
      mr_q <= win_row;
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow tracking
  // ---------------------------------------------------------------------------
`ifdef SPRITE_STORE_OVERFLOW_EN
  logic       drop_hit;
  logic       ovf_q;
  logic [5:0] drop_cnt;

  assign drop_hit = scan_acc && hit && (fill_cnt >= CNT_W'(MAX_SPRITES));

  always_ff @(posedge clk1) begin
    if (reset_video || scan_start) begin
      ovf_q    <= 1'b0;
      drop_cnt <= '0;
    end else if (drop_hit) begin
      ovf_q <= 1'b1;
      if (drop_cnt != 6'd63) begin
        drop_cnt <= drop_cnt + 6'd1;
      end
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_scan_store.sv
// Directed + randomized bench for sprite_scan_store with a queue-based reference model.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled there too.
// The model holds the stored sprites as a queue in OAM order and picks the first unconsumed X match.

module tb_sprite_scan_store;

  localparam int MAXS   = 10;
  localparam int NENT   = 40;
  localparam int IDX_W  = 6;
  localparam int SLOT_W = 4;

  logic              clk1 = 1'b0;
  logic              reset_video = 1'b1;
  logic              scan_start = 1'b0;
  logic [7:0]        line = '0;
  logic              tall_mode = 1'b0;
  logic              oam_valid = 1'b0;
  logic [7:0]        oam_y = '0;
  logic [7:0]        oam_x = '0;
  logic [IDX_W-1:0]  oam_idx = '0;
  logic              render_en = 1'b0;
  logic [7:0]        cur_x = '0;
  logic              fetch_done = 1'b0;
  logic              scan_busy;
  logic [SLOT_W-1:0] store_count;
  logic              match_valid;
  logic [SLOT_W-1:0] match_slot;
  logic [IDX_W-1:0]  match_idx;
  logic [3:0]        match_row;
  logic              overflow;

  sprite_scan_store #(
    .MAX_SPRITES(MAXS),
    .OAM_ENTRIES(NENT),
    .IDX_W(IDX_W),
    .SLOT_W(SLOT_W)
  ) dut (
    .clk1(clk1),
    .reset_video(reset_video),
    .scan_start(scan_start),
    .line(line),
    .tall_mode(tall_mode),
    .oam_valid(oam_valid),
    .oam_y(oam_y),
    .oam_x(oam_x),
    .oam_idx(oam_idx),
    .render_en(render_en),
    .cur_x(cur_x),
    .fetch_done(fetch_done),
    .scan_busy(scan_busy),
    .store_count(store_count),
    .match_valid(match_valid),
    .match_slot(match_slot),
    .match_idx(match_idx),
    .match_row(match_row),
    .overflow(overflow)
  );

  always #5 clk1 = ~clk1;

  typedef struct {
    int idx;
    int x;
    int row;
    bit used;
  } spr_t;

  spr_t mq[$];
  int   drops;
  int   ys[64];
  int   xs[64];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  function automatic int exp_ovf();
`ifdef SPRITE_STORE_OVERFLOW_EN
    return (drops > 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // Index of the first unconsumed stored sprite at X, or -1.
  function automatic int find_x(input int x);
    for (int k = 0; k < mq.size(); k++) begin
      if (!mq[k].used && mq[k].x == x) return k;
    end
    return -1;
  endfunction

  task automatic fill_miss();
    for (int e = 0; e < 64; e++) begin
      ys[e] = 200;
      xs[e] = $urandom_range(0, 255);
    end
  endtask

  // Start a scan and feed entries 0..n-1 with random idle gaps.
  task automatic run_scan(input int ln, input bit tall, input int n);
    render_en  = 1'b0;
    fetch_done = 1'b0;
    oam_valid  = 1'b0;
    scan_start = 1'b1;
    tall_mode  = tall;
    tick();
    scan_start = 1'b0;
    tall_mode  = !tall;  // must have been latched at scan_start
    mq.delete();
    drops = 0;
    chk("start_busy", scan_busy, 1);
    chk("start_count", store_count, 0);
    chk("start_ovf", overflow, 0);
    line = 8'(ln);
    for (int e = 0; e < n; e++) begin
      int d;
      if ($urandom_range(0, 3) == 0) begin
        tick();
      end
      oam_valid = 1'b1;
      oam_y     = 8'(ys[e]);
      oam_x     = 8'(xs[e]);
      oam_idx   = 6'(e);
      tick();
      oam_valid = 1'b0;
      d = (ln + 16 - ys[e]) & 255;
      if (d < (tall ? 16 : 8)) begin
        if (mq.size() < MAXS) mq.push_back('{idx: e, x: xs[e], row: d & 15, used: 1'b0});
        else drops++;
      end
      chk("scan_count", store_count, mq.size());
      chk("scan_busy", scan_busy, (e != NENT - 1) ? 1 : 0);
    end
    chk("scan_ovf", overflow, exp_ovf());
  endtask

  task automatic enter_render();
    render_en = 1'b1;
    tick();
  endtask

  // Present every stored sprite at X in slot order, acknowledging each.
  task automatic check_x(input int x);
    cur_x = 8'(x);
    tick();
    for (int it = 0; it <= MAXS; it++) begin
      int k;
      k = find_x(x);
      chk("mx_valid", match_valid, (k >= 0) ? 1 : 0);
      if (k < 0) break;
      chk("mx_slot", match_slot, k);
      chk("mx_idx", match_idx, mq[k].idx);
      chk("mx_row", match_row, mq[k].row);
      fetch_done = 1'b1;
      tick();
      fetch_done = 1'b0;
      chk("mx_gap", match_valid, 0);
      mq[k].used = 1'b1;
      tick();
    end
  endtask

  task automatic leave_render();
    render_en = 1'b0;
    tick();
    chk("idle_valid", match_valid, 0);
  endtask

  initial begin
    // Reset
    tick();
    tick();
    chk("rst_busy", scan_busy, 0);
    chk("rst_count", store_count, 0);
    chk("rst_valid", match_valid, 0);
    chk("rst_slot", match_slot, 0);
    chk("rst_idx", match_idx, 0);
    chk("rst_row", match_row, 0);
    chk("rst_ovf", overflow, 0);
    reset_video = 1'b0;
    tick();

    // Basic scan: hits at idx 3 and 17 only
    fill_miss();
    ys[3]  = 36;
    ys[17] = 36;
    run_scan(20, 1'b0, NENT);
    chk("basic_count", store_count, 2);
    // OAM entries outside SCAN are ignored
    oam_valid = 1'b1;
    oam_y     = 8'd36;
    tick();
    oam_valid = 1'b0;
    chk("ready_ignore", store_count, 2);

    // Tall mode: diff 11 stored in 16-row mode, not in 8-row mode
    fill_miss();
    ys[0] = 25;
    xs[0] = 50;
    run_scan(20, 1'b1, NENT);
    chk("tall_count", store_count, 1);
    enter_render();
    check_x(50);
    leave_render();
    run_scan(20, 1'b0, NENT);
    chk("short_count", store_count, 0);

    // Overflow: 12 consecutive hits
    fill_miss();
    for (int e = 0; e < 12; e++) ys[e] = 36 - $urandom_range(0, 7);
    run_scan(20, 1'b0, NENT);
    chk("ovf_count", store_count, 10);
    chk("ovf_drops", drops, 2);
    enter_render();
    for (int k = 0; k < 12; k++) check_x(xs[k]);
    leave_render();

    // Priority and hold: slots 2 and 5 share x = 40
    fill_miss();
    for (int e = 0; e < 6; e++) ys[e] = 36;
    xs[0] = 10; xs[1] = 20; xs[2] = 40; xs[3] = 30; xs[4] = 50; xs[5] = 40;
    run_scan(20, 1'b0, NENT);
    chk("prio_count", store_count, 6);
    enter_render();
    cur_x = 8'd40;
    tick();
    chk("prio_valid", match_valid, 1);
    chk("prio_slot", match_slot, 2);
    chk("prio_idx", match_idx, 2);
    cur_x = 8'd10;
    tick();
    chk("hold1_slot", match_slot, 2);
    cur_x = 8'd50;
    tick();
    chk("hold2_valid", match_valid, 1);
    chk("hold2_slot", match_slot, 2);
    cur_x = 8'd40;
    fetch_done = 1'b1;
    tick();
    fetch_done = 1'b0;
    chk("prio_gap", match_valid, 0);
    tick();
    chk("next_valid", match_valid, 1);
    chk("next_slot", match_slot, 5);
    fetch_done = 1'b1;
    tick();
    fetch_done = 1'b0;
    chk("done_gap", match_valid, 0);
    tick();
    chk("all_used", match_valid, 0);
    // fetch_done with nothing presented must not consume anything
    cur_x = 8'd99;
    fetch_done = 1'b1;
    tick();
    fetch_done = 1'b0;
    chk("stray_done", match_valid, 0);
    cur_x = 8'd10;
    tick();
    chk("after_stray_valid", match_valid, 1);
    chk("after_stray_slot", match_slot, 0);
    leave_render();
    chk("idle_busy", scan_busy, 0);

    // Restart mid-SCAN after 20 entries with 3 stored, then a full rescan
    fill_miss();
    for (int e = 0; e < 3; e++) ys[e] = 36;
    run_scan(20, 1'b0, 20);
    chk("part_count", store_count, 3);
    run_scan(20, 1'b0, NENT);
    chk("restart_count", store_count, 3);
    // Reset in the middle of RENDER
    enter_render();
    cur_x = 8'(xs[0]);
    tick();
    chk("pre_rst_valid", match_valid, 1);
    reset_video = 1'b1;
    tick();
    chk("mrst_valid", match_valid, 0);
    chk("mrst_slot", match_slot, 0);
    chk("mrst_idx", match_idx, 0);
    chk("mrst_row", match_row, 0);
    chk("mrst_count", store_count, 0);
    chk("mrst_busy", scan_busy, 0);
    chk("mrst_ovf", overflow, 0);
    reset_video = 1'b0;
    tick();
    chk("post_rst_valid", match_valid, 0);
    render_en = 1'b0;

    // Wrap: line 250 / y 10 hits with row 0; line 0 / y 0 never hits
    fill_miss();
    ys[5] = 10;
    run_scan(250, 1'b0, NENT);
    chk("wrap_count", store_count, 1);
    enter_render();
    check_x(xs[5]);
    leave_render();
    fill_miss();
    ys[7] = 0;
    run_scan(0, 1'b1, NENT);
    chk("wrap16_count", store_count, 0);
    run_scan(0, 1'b0, NENT);
    chk("wrap8_count", store_count, 0);

    // Randomized scans with colliding X values (including X = 0)
    for (int r = 0; r < 4; r++) begin
      int ln;
      bit tall;
      ln   = $urandom_range(0, 255);
      tall = 1'($urandom_range(0, 1));
      for (int e = 0; e < 64; e++) begin
        ys[e] = (ln + 16 - $urandom_range(0, 24)) & 255;
        xs[e] = 8 * $urandom_range(0, 3);
      end
      run_scan(ln, tall, NENT);
      enter_render();
      for (int v = 0; v < 4; v++) check_x(8 * v);
      leave_render();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
